// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file types and defaults for the writeback arbiter slice.
package rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: one valid/ready lane per requester, packed with lane 0 at the LSBs.
// Handshake: a lane transfers on a posedge where req_valid[i] & req_ready[i]; valid never waits on ready.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = rf_pkg::ADDR_W,
    parameter int DATA_W  = rf_pkg::DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_dat;

    modport master (
        output req_valid,
        output req_reg,
        output req_dat,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_dat,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, gnt is one-hot or zero.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int PTR_W = $clog2(N);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = PTR_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the regfile write port among NUM_REQ writeback sources, with x0 drop and a
// saturating commit counter. Define RF_WB_BYPASS_EN to add the two write-to-read forwarding ports.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = rf_pkg::ADDR_W,
    parameter int DATA_W  = rf_pkg::DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    regfile_wb_arbiter_if.slave        req_if,
    output logic                       write,
    output logic [ADDR_W-1:0]          w_reg,
    output logic [DATA_W-1:0]          w_dat,
    output logic [CNT_W-1:0]           wr_cnt
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]          fwd_reg0,
    input  logic [ADDR_W-1:0]          fwd_reg1,
    output logic                       fwd_hit0,
    output logic                       fwd_hit1,
    output logic [DATA_W-1:0]          fwd_dat0,
    output logic [DATA_W-1:0]          fwd_dat1
`endif
);

    import rf_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               grant_en;
    logic               xfer;

    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_dat;

    logic               write_q, write_d;
    logic [ADDR_W-1:0]  w_reg_q;
    logic [DATA_W-1:0]  w_dat_q;
    logic [CNT_W-1:0]   wr_cnt_q;

    assign grant_en = !rst && !hold;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req     (req_if.req_valid),
        .ptr     (rr_ptr_q),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_if.req_ready = gnt;
    assign xfer             = |(gnt & req_if.req_valid);

    always_comb begin
        sel_reg = '0;
        sel_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_reg = req_if.req_reg[i*ADDR_W +: ADDR_W];
                sel_dat = req_if.req_dat[i*DATA_W +: DATA_W];
            end
        end
    end

    // The pointer moves past the winner even for x0 writes so a stream of x0 cannot starve others.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    assign write_d = xfer && (sel_reg != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            write_q  <= 1'b0;
            w_reg_q  <= '0;
            w_dat_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            write_q  <= write_d;
            if (xfer) begin
                w_reg_q <= sel_reg;
                w_dat_q <= sel_dat;
            end
            if (write_d && (wr_cnt_q != {CNT_W{1'b1}})) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign write  = write_q;
    assign w_reg  = w_reg_q;
    assign w_dat  = w_dat_q;
    assign wr_cnt = wr_cnt_q;

`ifdef RF_WB_BYPASS_EN
    // Readers of the regfile see this write one edge late, so expose it directly while it is pending.
    assign fwd_hit0 = write_q && (w_reg_q == fwd_reg0) && (fwd_reg0 != ADDR_W'(ZERO_REG));
    assign fwd_hit1 = write_q && (w_reg_q == fwd_reg1) && (fwd_reg1 != ADDR_W'(ZERO_REG));
    assign fwd_dat0 = fwd_hit0 ? w_dat_q : '0;
    assign fwd_dat1 = fwd_hit1 ? w_dat_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, grant order, x0 drop, hold, mid-op reset, saturation, bypass.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int W       = ADDR_W + DATA_W;

    // clock / reset
    logic clk;
    logic rst;
    logic hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sat_bus ();

    assign sat_bus.req_valid = bus.req_valid;
    assign sat_bus.req_reg   = bus.req_reg;
    assign sat_bus.req_dat   = bus.req_dat;

    logic              write, sat_write;
    logic [ADDR_W-1:0] w_reg, sat_w_reg;
    logic [DATA_W-1:0] w_dat, sat_w_dat;
    logic [15:0]       wr_cnt;
    logic [1:0]        sat_cnt;

`ifdef RF_WB_BYPASS_EN
    logic [ADDR_W-1:0] fwd_reg0, fwd_reg1, s_fwd_reg0, s_fwd_reg1;
    logic              fwd_hit0, fwd_hit1, s_fwd_hit0, s_fwd_hit1;
    logic [DATA_W-1:0] fwd_dat0, fwd_dat1, s_fwd_dat0, s_fwd_dat1;
    assign s_fwd_reg0 = '0;
    assign s_fwd_reg1 = '0;
`endif

    regfile_wb_arbiter #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .hold   (hold),
        .req_if (bus.slave),
        .write  (write),
        .w_reg  (w_reg),
        .w_dat  (w_dat),
        .wr_cnt (wr_cnt)
`ifdef RF_WB_BYPASS_EN
        ,
        .fwd_reg0 (fwd_reg0),
        .fwd_reg1 (fwd_reg1),
        .fwd_hit0 (fwd_hit0),
        .fwd_hit1 (fwd_hit1),
        .fwd_dat0 (fwd_dat0),
        .fwd_dat1 (fwd_dat1)
`endif
    );

    // Same stimulus, 2-bit counter, to watch saturation.
    regfile_wb_arbiter #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (2)
    ) dut_sat (
        .clk    (clk),
        .rst    (rst),
        .hold   (hold),
        .req_if (sat_bus.slave),
        .write  (sat_write),
        .w_reg  (sat_w_reg),
        .w_dat  (sat_w_dat),
        .wr_cnt (sat_cnt)
`ifdef RF_WB_BYPASS_EN
        ,
        .fwd_reg0 (s_fwd_reg0),
        .fwd_reg1 (s_fwd_reg1),
        .fwd_hit0 (s_fwd_hit0),
        .fwd_hit1 (s_fwd_hit1),
        .fwd_dat0 (s_fwd_dat0),
        .fwd_dat1 (s_fwd_dat1)
`endif
    );

    // scoreboard
    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.req_reg[i*ADDR_W +: ADDR_W] = r;
        bus.req_dat[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_ready"}, 64'(bus.req_ready), 64'h0);
        check({tag, "_write"}, 64'(write), 64'h0);
        check({tag, "_w_reg"}, 64'(w_reg), 64'h0);
        check({tag, "_w_dat"}, 64'(w_dat), 64'h0);
        check({tag, "_cnt"}, 64'(wr_cnt), 64'h0);
        check({tag, "_sat_cnt"}, 64'(sat_cnt), 64'h0);
    endtask

    logic [W-1:0] exp_w;

    initial begin
        rst  = 1'b1;
        hold = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_reg   = '0;
        bus.req_dat   = '0;
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hB1);
`ifdef RF_WB_BYPASS_EN
        fwd_reg0 = '0;
        fwd_reg1 = '0;
`endif

        // reset held two cycles with both lanes valid
        repeat (2) begin
            tick();
            check_idle_reset("reset");
        end

        // single request from lane 0
        rst = 1'b0;
        bus.req_valid = 2'b01;
        set_req(0, 5'd3, 32'h2A);
        settle();
        check("single_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 2'b00;
        check("single_write", 64'(write), 64'h1);
        check("single_w_reg", 64'(w_reg), 64'h3);
        check("single_w_dat", 64'(w_dat), 64'h2A);
        check("single_cnt", 64'(wr_cnt), 64'h1);
        check("single_sat_cnt", 64'(sat_cnt), 64'h1);

        // x0 write from lane 1: accepted, not committed, pointer wraps to 0
        bus.req_valid = 2'b10;
        set_req(1, 5'd0, 32'h55);
        settle();
        check("x0_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 2'b00;
        check("x0_write", 64'(write), 64'h0);
        check("x0_w_reg", 64'(w_reg), 64'h0);
        check("x0_w_dat", 64'(w_dat), 64'h55);
        check("x0_cnt", 64'(wr_cnt), 64'h1);

        // contention: 4 back-to-back grants alternating 0,1,0,1
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hB1);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("cont_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            exp_q.push_back((k % 2 == 0) ? {5'd1, 32'hA0} : {5'd2, 32'hB1});
            tick();
            exp_w = exp_q.pop_front();
            check("cont_write", 64'(write), 64'h1);
            check("cont_w_reg", 64'(w_reg), 64'(exp_w[W-1:DATA_W]));
            check("cont_w_dat", 64'(w_dat), 64'(exp_w[DATA_W-1:0]));
        end
        bus.req_valid = 2'b00;
        tick();
        check("idle_write", 64'(write), 64'h0);
        check("idle_w_reg_hold", 64'(w_reg), 64'h2);
        check("idle_w_dat_hold", 64'(w_dat), 64'hB1);
        check("cont_cnt", 64'(wr_cnt), 64'd5);
        check("sat_cnt_max", 64'(sat_cnt), 64'd3);

        // hold: in-flight write completes, grants suppressed, pointer frozen at 1
        bus.req_valid = 2'b01;
        settle();
        check("pre_hold_ready", 64'(bus.req_ready), 64'h1);
        tick();
        hold = 1'b1;
        bus.req_valid = 2'b11;
        settle();
        check("hold_ready", 64'(bus.req_ready), 64'h0);
        check("hold_inflight_write", 64'(write), 64'h1);
        check("hold_inflight_cnt", 64'(wr_cnt), 64'd6);
        tick();
        check("hold_write0", 64'(write), 64'h0);
        tick();
        check("hold_write1", 64'(write), 64'h0);
        check("hold_cnt", 64'(wr_cnt), 64'd6);
        hold = 1'b0;
        settle();
        check("release_ready", 64'(bus.req_ready), 64'h2);
        tick();
        check("release_write", 64'(write), 64'h1);
        check("release_w_reg", 64'(w_reg), 64'h2);
        check("release_w_dat", 64'(w_dat), 64'hB1);
        check("release_cnt", 64'(wr_cnt), 64'd7);
        check("sat_cnt_stays", 64'(sat_cnt), 64'd3);

        // reset the cycle after an accept discards the registered write
        bus.req_valid = 2'b01;
        settle();
        check("pre_rst_ready", 64'(bus.req_ready), 64'h1);
        tick();
        check("pre_rst_write", 64'(write), 64'h1);
        check("pre_rst_cnt", 64'(wr_cnt), 64'd8);
        rst = 1'b1;
        bus.req_valid = 2'b11;
        settle();
        check("midrst_ready", 64'(bus.req_ready), 64'h0);
        tick();
        check_idle_reset("midrst");
        rst = 1'b0;
        bus.req_valid = 2'b00;
        settle();
        check("post_rst_ready", 64'(bus.req_ready), 64'h0);

`ifdef RF_WB_BYPASS_EN
        bus.req_valid = 2'b01;
        set_req(0, 5'd7, 32'h1234_5678);
        tick();
        bus.req_valid = 2'b00;
        fwd_reg0 = 5'd7;
        fwd_reg1 = 5'd0;
        settle();
        check("fwd_hit0", 64'(fwd_hit0), 64'h1);
        check("fwd_dat0", 64'(fwd_dat0), 64'h1234_5678);
        check("fwd_x0_hit1", 64'(fwd_hit1), 64'h0);
        check("fwd_x0_dat1", 64'(fwd_dat1), 64'h0);
        fwd_reg1 = 5'd3;
        settle();
        check("fwd_miss_hit1", 64'(fwd_hit1), 64'h0);
        tick();
        check("fwd_idle_hit0", 64'(fwd_hit0), 64'h0);
        check("fwd_idle_dat0", 64'(fwd_dat0), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
